led_matrix_engine: RTL and testbench
====================================

// Module: led_matrix_engine
// PURPOSE
//  Parametrised successor to the 8x8 two-colour point-matrix driver: multi-channel, multi-level (grey-scale) scan engine.
//  Holds a ROWS x COLS x CH x BPP framebuffer, accepts pixel writes from the light-pen/state-machine side, and
//  time-multiplexes rows with per-pixel PWM. Adds inter-row ghost blanking, a frame sync and a sequenced clear.
//  Sits between the top-level state machine (mode/write source) and the matrix pins.
// PARAMETERS
//  ROWS        8    number of matrix rows (>=2)
//  COLS        8    number of matrix columns (>=2)
//  CH          2    colour channels (0=red, 1=green, ...)
//  BPP         2    brightness bits per channel; LEVELS = 2**BPP
//  PRESCALE    64   clk cycles per PWM slot tick (>=1)
//  BLANK_TICKS 1    ticks with all rows off after each row (>=0)
// PORTS
//  clk         in   1             system clock
//  rst         in   1             asynchronous reset, active-high
//  mode        in   2             display mode (led_pkg: MODE_NORMAL/MODE_REVERSE/MODE_BLANK/MODE_TEST)
//  clean       in   1             pulse: start framebuffer clear
//  wr_en       in   1             pixel write strobe
//  wr_row      in   $clog2(ROWS)  write row address
//  wr_col      in   $clog2(COLS)  write column address
//  wr_data     in   CH*BPP        pixel value, channel c at [c*BPP +: BPP]
//  swap_req    in   1             request buffer swap (LED_DBUF_EN only; ignored otherwise)
//  output_row  out  ROWS          row drive, active-low
//  output_col  out  CH*COLS       column drive, active-high, channel c at [c*COLS +: COLS]
//  row_d       out  $clog2(ROWS)  row of last accepted write
//  col_d       out  $clog2(COLS)  column of last accepted write
//  clr_busy    out  1             high while clear sweep runs
//  frame_start out  1             1-cycle pulse when row 0 scan begins
//  swap_ack    out  1             1-cycle pulse when swap executed (0 without LED_DBUF_EN)
// BEHAVIOUR
//  Reset: output_row all 1, output_col all 0, row_d/col_d 0, clr_busy 0, frame_start 0, swap_ack 0;
//   framebuffer all 0; scan row 0, slot 0, FSM=SCAN, prescaler 0.
//  Tick: prescaler counts 0..PRESCALE-1; tick asserted on terminal count.
//  FSM SCAN: slot s = 0..LEVELS-2 advances per tick; after slot LEVELS-2 -> BLANK (or next row if BLANK_TICKS=0).
//  FSM BLANK: rows off for BLANK_TICKS ticks, then row+1 (wrap ROWS-1 -> 0) and back to SCAN, slot 0.
//  frame_start pulses on the clk the scan enters row 0 slot 0 (also first cycle after reset release).
//  Pixel lit in slot s iff lvl > s; lvl = stored level (NORMAL) or LEVELS-1-level (REVERSE).
//  MODE_BLANK: rows all 1, cols all 0; scanning continues. MODE_TEST: current row, all cols all channels lit every slot.
//  Outputs registered: 1-cycle latency from counters/framebuffer to pins; mode change visible next cycle.
//  Write: wr_en with clr_busy=0 updates pixel at next clk edge; row_d/col_d update same edge.
//   Write to row being scanned takes effect in the current slot (+1 clk); no tearing protection without DBUF.
//  Clear: clean starts a sweep of one pixel/clk, ROWS*COLS cycles, clr_busy high throughout; writes dropped.
//   clean while busy restarts sweep from pixel 0. clean and wr_en same cycle: clear wins, write dropped.
//  Out-of-range wr_row/wr_col (non-power-of-2 sizes): write ignored, row_d/col_d unchanged.
//  Reset mid-clear or mid-frame: immediate return to reset state, framebuffer zeroed.
// CONFIGURATION
//  LED_DBUF_EN defined: two framebuffers; writes/clear target back buffer, scan reads front buffer.
//   swap_req latched (sticky) until frame end; swap executes with frame_start, swap_ack pulses same cycle.
//   Swap deferred while clr_busy. Repeated swap_req before frame end -> single swap.
//  LED_DBUF_EN undefined: single buffer, swap_req ignored, swap_ack tied 0.
// STRUCTURE
//  led_pkg: MODE_* encodings, FSM state encoding (ST_SCAN, ST_BLANK), width helper functions.
//  Sub-module led_fb: framebuffer storage, write port, clear sequencer, optional double buffer and swap.
//  Top: prescaler, scan FSM, slot/row counters, level compare, mode mux, output registers.
// TESTING
//  Reset, ROWS=8, PRESCALE=4, BLANK_TICKS=1, BPP=2 -> frame_start period 8*(3+1)*4=128 clk; pins idle values.
//  Write (r2,c5) red=2 -> output_col[5] high 2 of 3 slots when output_row[2]=0; other pixels off.
//  Same pixel, MODE_REVERSE -> lit 1 of 3 slots; unwritten pixels lit 3 of 3.
//  clean at t, wr_en at t and t+10 -> both writes dropped, clr_busy high 64 clk, framebuffer all 0.
//  MODE_BLANK mid-row -> next cycle output_row=all 1, output_col=0; frame_start cadence unchanged.
//  LED_DBUF_EN: write back buffer, swap_req mid-frame -> display unchanged until frame_start; swap_ack coincides.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings and width helpers for the LED matrix scan engine.
// Optional feature macro used by the engine: LED_DBUF_EN (double-buffered framebuffer).
package led_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_REVERSE = 2'd1,
        MODE_BLANK   = 2'd2,
        MODE_TEST    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_fb.sv
// Framebuffer for the LED matrix engine: pixel write port, one-pixel-per-clock clear sweep,
// full-row read for the scanner. With LED_DBUF_EN defined it holds front/back buffers and a frame-synchronous swap.
module led_fb
    import led_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int CH   = 2,
    parameter int BPP  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clean,
    input  logic                        wr_en,
    input  logic [$clog2(ROWS)-1:0]     wr_row,
    input  logic [$clog2(COLS)-1:0]     wr_col,
    input  logic [CH*BPP-1:0]           wr_data,
    input  logic                        swap_req,
    input  logic                        frame_tick,
    input  logic [$clog2(ROWS)-1:0]     rd_row,
    output logic [COLS*CH*BPP-1:0]      rd_pix,
    output logic [$clog2(ROWS)-1:0]     row_d,
    output logic [$clog2(COLS)-1:0]     col_d,
    output logic                        clr_busy,
    output logic                        swap_ack
);

    localparam int PIX_W = CH * BPP;
    localparam int NPIX  = ROWS * COLS;
    localparam int AW    = clog2_min1(NPIX);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
`ifdef LED_DBUF_EN
    localparam int NBUF  = 2;
`else
    localparam int NBUF  = 1;
`endif

    logic [PIX_W-1:0] mem_q [NBUF][NPIX];
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic             clr_busy_q, clr_busy_d;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             wr_ok;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_base;
    logic             wr_buf;
    logic             rd_buf;

    // A write is dropped while a sweep runs or starts; out-of-range addresses only matter for non-power-of-2 sizes.
    assign wr_ok   = wr_en && !clean && !clr_busy_q
                     && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));
    assign rd_base = AW'(int'(rd_row) * COLS);

    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_idx_d  = clr_idx_q;
        if (clean) begin
            clr_busy_d = 1'b1;
            clr_idx_d  = '0;
        end else if (clr_busy_q) begin
            if (clr_idx_q == AW'(NPIX - 1)) begin
                clr_busy_d = 1'b0;
            end else begin
                clr_idx_d = clr_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_busy_q <= 1'b0;
            clr_idx_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_idx_q  <= clr_idx_d;
            if (wr_ok) begin
                row_q <= wr_row;
                col_q <= wr_col;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBUF; b++) begin
                for (int a = 0; a < NPIX; a++) begin
                    mem_q[b][a] <= '0;
                end
            end
        end else if (clr_busy_q) begin
            mem_q[wr_buf][clr_idx_q] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_buf][wr_addr] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_rd
            assign rd_pix[gi*PIX_W +: PIX_W] = mem_q[rd_buf][rd_base + AW'(gi)];
        end
    endgenerate

`ifdef LED_DBUF_EN
    logic front_q, front_d;
    logic swap_pend_q, swap_pend_d;
    logic swap_ack_q;
    logic do_swap;

    // The swap waits for the next frame boundary and never lands in the middle of a clear sweep.
    assign do_swap     = (swap_pend_q || swap_req) && frame_tick && !clr_busy_q;
    assign front_d     = front_q ^ do_swap;
    assign swap_pend_d = (swap_pend_q || swap_req) && !do_swap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            front_q     <= front_d;
            swap_pend_q <= swap_pend_d;
            swap_ack_q  <= do_swap;
        end
    end

    assign wr_buf   = ~front_q;
    assign rd_buf   = front_q;
    assign swap_ack = swap_ack_q;
`else
    logic unused_swap;
    assign unused_swap = ^{swap_req, frame_tick};
    assign wr_buf      = 1'b0;
    assign rd_buf      = 1'b0;
    assign swap_ack    = 1'b0;
`endif

    assign row_d    = row_q;
    assign col_d    = col_q;
    assign clr_busy = clr_busy_q;

endmodule

// File: rtl/led_matrix_engine.sv
// Grey-scale multi-channel LED matrix scan engine: prescaler, row/slot scan FSM with ghost blanking, PWM compare.
// Define LED_DBUF_EN to build the double-buffered framebuffer with frame-synchronous swap.
module led_matrix_engine
    import led_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int CH          = 2,
    parameter int BPP         = 2,
    parameter int PRESCALE    = 64,
    parameter int BLANK_TICKS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        clean,
    input  logic                        wr_en,
    input  logic [$clog2(ROWS)-1:0]     wr_row,
    input  logic [$clog2(COLS)-1:0]     wr_col,
    input  logic [CH*BPP-1:0]           wr_data,
    input  logic                        swap_req,
    output logic [ROWS-1:0]             output_row,
    output logic [CH*COLS-1:0]          output_col,
    output logic [$clog2(ROWS)-1:0]     row_d,
    output logic [$clog2(COLS)-1:0]     col_d,
    output logic                        clr_busy,
    output logic                        frame_start,
    output logic                        swap_ack
);

    localparam int LEVELS = 1 << BPP;
    localparam int PIX_W  = CH * BPP;
    localparam int RW     = $clog2(ROWS);
    localparam int PW     = clog2_min1(PRESCALE);
    localparam int BW     = clog2_min1(BLANK_TICKS + 1);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [BPP-1:0] SLOT_LAST  = BPP'(LEVELS - 2);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
    localparam logic [BW-1:0]  BLANK_LAST = (BLANK_TICKS > 0) ? BW'(BLANK_TICKS - 1) : '0;

    scan_state_e            state_q, state_d;
    logic [RW-1:0]          scan_row_q, scan_row_d;
    logic [BPP-1:0]         slot_q, slot_d;
    logic [BW-1:0]          blank_q, blank_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   start_q, start_d;
    logic                   fs_d;
    logic                   row_adv;
    logic                   tick;
    logic                   frame_start_q;
    logic [ROWS-1:0]        out_row_q, out_row_d;
    logic [CH*COLS-1:0]     out_col_q, out_col_d;
    logic [COLS*PIX_W-1:0]  rd_pix;
    logic [CH*COLS-1:0]     lit_vec;
    mode_e                  mode_s;
    logic                   reverse;

    assign mode_s  = mode_e'(mode);
    assign reverse = (mode_s == MODE_REVERSE);
    assign tick    = (presc_q == PRESC_LAST);

    led_fb #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CH   (CH),
        .BPP  (BPP)
    ) u_fb (
        .clk        (clk),
        .rst        (rst),
        .clean      (clean),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .frame_tick (fs_d),
        .rd_row     (scan_row_q),
        .rd_pix     (rd_pix),
        .row_d      (row_d),
        .col_d      (col_d),
        .clr_busy   (clr_busy),
        .swap_ack   (swap_ack)
    );

    // The first cycle after reset only announces the frame; counters start moving one clock later
    // so every frame_start pulse lines up with prescaler 0 of row 0, slot 0.
    always_comb begin
        state_d    = state_q;
        scan_row_d = scan_row_q;
        slot_d     = slot_q;
        blank_d    = blank_q;
        presc_d    = presc_q;
        start_d    = 1'b0;
        fs_d       = 1'b0;
        row_adv    = 1'b0;
        if (start_q) begin
            fs_d = 1'b1;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                case (state_q)
                    ST_SCAN: begin
                        if (slot_q == SLOT_LAST) begin
                            if (BLANK_TICKS == 0) begin
                                row_adv = 1'b1;
                            end else begin
                                state_d = ST_BLANK;
                                blank_d = '0;
                            end
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        if (blank_q == BLANK_LAST) begin
                            row_adv = 1'b1;
                        end else begin
                            blank_d = blank_q + 1'b1;
                        end
                    end
                endcase
            end
            if (row_adv) begin
                state_d    = ST_SCAN;
                slot_d     = '0;
                scan_row_d = (scan_row_q == ROW_LAST) ? '0 : scan_row_q + 1'b1;
                fs_d       = (scan_row_q == ROW_LAST);
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            for (gj = 0; gj < CH; gj++) begin : g_ch
                logic [BPP-1:0] lvl;
                // Bitwise inversion of an unsigned level is LEVELS-1-level.
                assign lvl = reverse ? ~rd_pix[gi*PIX_W + gj*BPP +: BPP]
                                     :  rd_pix[gi*PIX_W + gj*BPP +: BPP];
                assign lit_vec[gj*COLS + gi] = (lvl > slot_q);
            end
        end
    endgenerate

    always_comb begin
        out_row_d = '1;
        out_col_d = '0;
        if (state_q == ST_SCAN && mode_s != MODE_BLANK) begin
            out_row_d = ~(ROWS'(1) << scan_row_q);
            out_col_d = (mode_s == MODE_TEST) ? '1 : lit_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SCAN;
            scan_row_q    <= '0;
            slot_q        <= '0;
            blank_q       <= '0;
            presc_q       <= '0;
            start_q       <= 1'b1;
            frame_start_q <= 1'b0;
            out_row_q     <= '1;
            out_col_q     <= '0;
        end else begin
            state_q       <= state_d;
            scan_row_q    <= scan_row_d;
            slot_q        <= slot_d;
            blank_q       <= blank_d;
            presc_q       <= presc_d;
            start_q       <= start_d;
            frame_start_q <= fs_d;
            out_row_q     <= out_row_d;
            out_col_q     <= out_col_d;
        end
    end

    assign output_row  = out_row_q;
    assign output_col  = out_col_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_engine.sv
// Directed scoreboard bench for led_matrix_engine (8x8, 2 channels, 2 bpp, prescale 4, one blank tick).
module tb_led_matrix_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        clean;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [2:0]  wr_col;
    logic [3:0]  wr_data;
    logic        swap_req;
    logic [7:0]  output_row;
    logic [15:0] output_col;
    logic [2:0]  row_d;
    logic [2:0]  col_d;
    logic        clr_busy;
    logic        frame_start;
    logic        swap_ack;

    int    checks = 0;
    int    errors = 0;
    int    exp_q[$];
    string tag_q[$];

    led_matrix_engine #(
        .ROWS(8), .COLS(8), .CH(2), .BPP(2), .PRESCALE(4), .BLANK_TICKS(1)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .clean(clean), .wr_en(wr_en),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .swap_req(swap_req),
        .output_row(output_row), .output_col(output_col), .row_d(row_d), .col_d(col_d),
        .clr_busy(clr_busy), .frame_start(frame_start), .swap_ack(swap_ack)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input int v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input int obs);
        string t;
        int    e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        assert (obs === e)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    // Steps negedges until frame_start is seen; steps is how many were taken.
    task automatic wait_fs(output int steps);
        int found;
        found = 0;
        steps = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            steps++;
            if (frame_start) found = 1;
        end
        push_exp("fs_found", 1);
        pop_check(found);
    endtask

    // Integrates pin activity over one 128-cycle frame starting at a frame_start cycle.
    task automatic measure(output int total, output int r25, output int g25,
                           output int r00, output int row2);
        total = 0; r25 = 0; g25 = 0; r00 = 0; row2 = 0;
        for (int i = 0; i < 128; i++) begin
            total += $countones(output_col);
            if (output_row == 8'hFB) begin
                row2++;
                r25 += int'(output_col[5]);
                g25 += int'(output_col[13]);
            end
            if (output_row == 8'hFE) r00 += int'(output_col[0]);
            @(negedge clk);
        end
    endtask

    initial begin
        int total, r25, g25, r00, row2, steps, busy_cnt;

        rst = 1'b1; mode = 2'd0; clean = 1'b0; wr_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; swap_req = 1'b0;
        repeat (3) @(negedge clk);

        push_exp("rst_row", 255);   pop_check(int'(output_row));
        push_exp("rst_col", 0);     pop_check(int'(output_col));
        push_exp("rst_row_d", 0);   pop_check(int'(row_d));
        push_exp("rst_col_d", 0);   pop_check(int'(col_d));
        push_exp("rst_busy", 0);    pop_check(int'(clr_busy));
        push_exp("rst_fs", 0);      pop_check(int'(frame_start));
        push_exp("rst_ack", 0);     pop_check(int'(swap_ack));

        rst = 1'b0;
        @(negedge clk);
        push_exp("fs_after_reset", 1);
        pop_check(int'(frame_start));
        measure(total, r25, g25, r00, row2);
        push_exp("empty_total", 0);     pop_check(total);
        push_exp("row2_cycles", 12);    pop_check(row2);
        push_exp("fs_period", 1);       pop_check(int'(frame_start));
        $display("reset frame: total=%0d row2=%0d", total, row2);

        wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd5; wr_data = 4'b0010;
        push_exp("wr_row_d", 2);
        push_exp("wr_col_d", 5);
        @(negedge clk);
        wr_en = 1'b0;
        pop_check(int'(row_d));
        pop_check(int'(col_d));
        $display("write r2 c5 red=2: row_d=%0d col_d=%0d", row_d, col_d);

        wait_fs(steps);
        measure(total, r25, g25, r00, row2);
        push_exp("norm_red25", 8);   pop_check(r25);
        push_exp("norm_grn25", 0);   pop_check(g25);
        push_exp("norm_total", 8);   pop_check(total);
        $display("normal frame: red25=%0d grn25=%0d total=%0d", r25, g25, total);

        mode = 2'd1;
        wait_fs(steps);
        measure(total, r25, g25, r00, row2);
        push_exp("rev_red25", 4);     pop_check(r25);
        push_exp("rev_grn25", 12);    pop_check(g25);
        push_exp("rev_red00", 12);    pop_check(r00);
        push_exp("rev_total", 1528);  pop_check(total);
        $display("reverse frame: red25=%0d grn25=%0d red00=%0d total=%0d", r25, g25, r00, total);

        mode = 2'd3;
        wait_fs(steps);
        measure(total, r25, g25, r00, row2);
        push_exp("test_total", 1536); pop_check(total);
        $display("test frame: total=%0d", total);

        mode = 2'd0;
        clean = 1'b1; wr_en = 1'b1; wr_row = 3'd3; wr_col = 3'd3; wr_data = 4'hF;
        busy_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            clean  = 1'b0;
            wr_en  = (k == 10);
            wr_row = 3'd4; wr_col = 3'd4;
            if (clr_busy) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        wr_en = 1'b0;
        push_exp("clr_busy_cycles", 64); pop_check(busy_cnt);
        push_exp("clr_row_d", 2);        pop_check(int'(row_d));
        push_exp("clr_col_d", 5);        pop_check(int'(col_d));
        wait_fs(steps);
        measure(total, r25, g25, r00, row2);
        push_exp("clr_total", 0);        pop_check(total);
        $display("clear: busy=%0d row_d=%0d col_d=%0d total=%0d", busy_cnt, row_d, col_d, total);

        wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd5; wr_data = 4'hF;
        @(negedge clk);
        wr_en = 1'b0;
        wait_fs(steps);
        repeat (9) @(negedge clk);
        mode = 2'd2;
        @(negedge clk);
        push_exp("blank_row", 255);  pop_check(int'(output_row));
        push_exp("blank_col", 0);    pop_check(int'(output_col));
        wait_fs(steps);
        push_exp("blank_fs_gap", 118); pop_check(steps);
        measure(total, r25, g25, r00, row2);
        push_exp("blank_total", 0);  pop_check(total);
        push_exp("blank_row2", 0);   pop_check(row2);
        $display("blank mode: fs_gap=%0d total=%0d row2=%0d", steps, total, row2);

        mode = 2'd0;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        wait_fs(steps);
        push_exp("swap_ack_off", 0); pop_check(int'(swap_ack));
        measure(total, r25, g25, r00, row2);
        push_exp("full_red25", 12);  pop_check(r25);
        push_exp("full_grn25", 12);  pop_check(g25);
        push_exp("full_total", 24);  pop_check(total);
        $display("swap ignored: ack=%0d red25=%0d grn25=%0d total=%0d", swap_ack, r25, g25, total);

        clean = 1'b1;
        @(negedge clk);
        clean = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_exp("midclr_busy", 0);  pop_check(int'(clr_busy));
        push_exp("midclr_row", 255); pop_check(int'(output_row));
        push_exp("midclr_row_d", 0); pop_check(int'(row_d));
        rst = 1'b0;
        wait_fs(steps);
        measure(total, r25, g25, r00, row2);
        push_exp("midclr_total", 0); pop_check(total);
        $display("reset mid-clear: busy=%0d total=%0d", clr_busy, total);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
